// File: rtl/posit_normalize_es3_pkg.sv
// -----------------------------------------------------------------------------
// posit_defines_es3
// Shared constants and types for the ES=3, 32-bit posit encoder.
//   NBITS     : posit width
//   ES        : exponent bits
//   FBITS     : stored fraction bits
//   ABITS     : unpacked fraction width (carry, hidden, fraction, guard, sticky)
//   MAX_SCALE : largest representable scale magnitude
//   value_sum : unpacked sum value as delivered by the adder datapath
//   rne_round : round-to-nearest-even on the 31-bit magnitude field
// -----------------------------------------------------------------------------
package posit_defines_es3;

   localparam int NBITS     = 32;
   localparam int ES        = 3;
   localparam int FBITS     = 26;
   localparam int ABITS     = FBITS + 4;
   localparam int MAX_SCALE = (1 << ES) * (NBITS - 2);
   localparam int SBITS     = 9;   // input scale width
   localparam int WBITS     = 11;  // widened scale width, cannot wrap

   localparam logic signed [WBITS-1:0] SCALE_MAX = WBITS'(MAX_SCALE);
   localparam logic signed [WBITS-1:0] SCALE_MIN = WBITS'(-MAX_SCALE);

   typedef struct packed {
      logic             sgn;
      logic [SBITS-1:0] scale;
      logic [ABITS-1:0] fraction;
      logic             inf;
      logic             zero;
   } value_sum;

   // RNE increment that never leaves maxpos and never produces zero.
   function automatic logic [NBITS-2:0] rne_round(
      input logic [NBITS-2:0] field,
      input logic             rnd,
      input logic             sticky
   );
      logic             inc;
      logic [NBITS-2:0] mag;
      inc = rnd & (sticky | field[0]) & (field != {(NBITS-1){1'b1}});
      mag = field + {{(NBITS-2){1'b0}}, inc};
      return (mag == {(NBITS-1){1'b0}}) ? {{(NBITS-2){1'b0}}, 1'b1} : mag;
   endfunction

endpackage

// File: rtl/posit_normalize_es3_lzc.sv
// -----------------------------------------------------------------------------
// posit_lzc
// Parameterised leading-zero counter; returns WIDTH when the input is all zero.
//   in_i  : vector to scan, MSB first
//   cnt_o : number of zeros above the highest set bit
// -----------------------------------------------------------------------------
module posit_lzc #(
   parameter int WIDTH = 29,
   parameter int CW    = 5
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [CW-1:0]    cnt_o
);

   // Scan from LSB upwards so the highest set bit is the last writer.
   always_comb begin
      cnt_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         cnt_o = in_i[i] ? CW'(WIDTH - 1 - i) : cnt_o;
      end
   end

endmodule

// File: rtl/posit_normalize_es3.sv
// -----------------------------------------------------------------------------
// posit_normalize_es3
// Three-stage pipelined encoder: unpacked ES=3 sum value -> 32-bit posit word.
//   Stage 1 normalises the fraction, stage 2 builds regime/exponent/fraction
//   with saturation, stage 3 rounds to nearest-even and applies the sign.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake
//   in_sgn, in_scale, in_fraction, in_inf, in_zero : unpacked value
//   out_valid / out_ready : output handshake
//   out_posit             : encoded posit
//   sat_count             : clamped-output counter
// Build option: define POSIT_NORM_SAT_CNT_EN to enable the saturation counter;
//   otherwise sat_count is tied to zero.
// -----------------------------------------------------------------------------
module posit_normalize_es3
   import posit_defines_es3::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sgn,
   input  logic [8:0]       in_scale,
   input  logic [29:0]      in_fraction,
   input  logic             in_inf,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_posit,
   output logic [15:0]      sat_count
);

   value_sum in_val_s;
   assign in_val_s = {in_sgn, in_scale, in_fraction, in_inf, in_zero};

   logic en_s;
   logic out_valid_q;
   logic [NBITS-1:0] out_posit_q;

   assign en_s      = !out_valid_q || out_ready;
   assign in_ready  = en_s;
   assign out_valid = out_valid_q;
   assign out_posit = out_posit_q;

   // ---------------- Stage 1: normalise ----------------
   logic [4:0]              lzc_s;
   logic signed [WBITS-1:0] scale_w_s;
   logic                    s1_zero_d;
   logic [ABITS-3:0]        s1_frac_d;   // hidden bit is implied after normalisation
   logic signed [WBITS-1:0] s1_scale_d;

   logic                    s1_valid_q, s1_sgn_q, s1_inf_q, s1_zero_q;
   logic [ABITS-3:0]        s1_frac_q;
   logic signed [WBITS-1:0] s1_scale_q;

   posit_lzc #(.WIDTH(ABITS - 1), .CW(5)) u_lzc (
      .in_i  (in_val_s.fraction[ABITS-2:0]),
      .cnt_o (lzc_s)
   );

   // Carry case shifts right with sticky collection; otherwise shift left by lzc.
   always_comb begin
      scale_w_s = $signed({{(WBITS-SBITS){in_val_s.scale[SBITS-1]}}, in_val_s.scale});
      s1_zero_d = in_val_s.zero | (in_val_s.fraction == {ABITS{1'b0}});
      if (in_val_s.fraction[ABITS-1]) begin
         s1_frac_d  = {in_val_s.fraction[ABITS-2:2], in_val_s.fraction[1] | in_val_s.fraction[0]};
         s1_scale_d = scale_w_s + 11'sd1;
      end else begin
         s1_frac_d  = in_val_s.fraction[ABITS-3:0] << lzc_s;
         s1_scale_d = scale_w_s - $signed({{(WBITS-5){1'b0}}, lzc_s});
      end
   end

   // ---------------- Stage 2: regime build ----------------
   logic [5:0]       k_s;
   logic [5:0]       shamt_s;
   logic [63:0]      x_s, xs_s;
   logic             clamp_hi_s, clamp_lo_s;
   logic [NBITS-2:0] s2_field_d;
   logic             s2_rnd_d, s2_stk_d;

   logic             s2_valid_q, s2_sgn_q, s2_inf_q, s2_zero_q, s2_rnd_q, s2_stk_q;
   logic [NBITS-2:0] s2_field_q;

   // Sign-extending shift of "10.." yields k+1 ones then a zero; "01.." shifted
   // by -k-1 yields -k zeros then a one. Top 31 bits are kept, next is round.
   always_comb begin
      k_s        = s1_scale_q[8:3];
      shamt_s    = k_s[5] ? ~k_s : k_s;
      x_s        = {(k_s[5] ? 2'b01 : 2'b10), s1_scale_q[2:0], s1_frac_q, 31'd0};
      xs_s       = $signed(x_s) >>> shamt_s;
      clamp_hi_s = s1_scale_q > SCALE_MAX;
      clamp_lo_s = s1_scale_q < SCALE_MIN;
      if (clamp_hi_s) begin
         s2_field_d = {(NBITS-1){1'b1}};
         s2_rnd_d   = 1'b0;
         s2_stk_d   = 1'b0;
      end else if (clamp_lo_s) begin
         s2_field_d = {{(NBITS-2){1'b0}}, 1'b1};
         s2_rnd_d   = 1'b0;
         s2_stk_d   = 1'b0;
      end else begin
         s2_field_d = xs_s[63:33];
         s2_rnd_d   = xs_s[32];
         s2_stk_d   = |xs_s[31:0];
      end
   end

   // ---------------- Stage 3: round and sign ----------------
   logic [NBITS-2:0] mag_s;
   logic [NBITS-1:0] posit_d;

   // NaR wins over zero; zero ignores the sign.
   always_comb begin
      mag_s = rne_round(s2_field_q, s2_rnd_q, s2_stk_q);
      if (s2_inf_q) begin
         posit_d = 32'h8000_0000;
      end else if (s2_zero_q) begin
         posit_d = 32'h0000_0000;
      end else if (s2_sgn_q) begin
         posit_d = 32'd0 - {1'b0, mag_s};
      end else begin
         posit_d = {1'b0, mag_s};
      end
   end

   // Pipeline registers: all stages advance together on en and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sgn_q    <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_frac_q   <= {(ABITS-2){1'b0}};
         s1_scale_q  <= {WBITS{1'b0}};
         s2_valid_q  <= 1'b0;
         s2_sgn_q    <= 1'b0;
         s2_inf_q    <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_rnd_q    <= 1'b0;
         s2_stk_q    <= 1'b0;
         s2_field_q  <= {(NBITS-1){1'b0}};
         out_valid_q <= 1'b0;
         out_posit_q <= {NBITS{1'b0}};
      end else if (en_s) begin
         s1_valid_q  <= in_valid;
         if (in_valid) begin
            s1_sgn_q   <= in_val_s.sgn;
            s1_inf_q   <= in_val_s.inf;
            s1_zero_q  <= s1_zero_d;
            s1_frac_q  <= s1_frac_d;
            s1_scale_q <= s1_scale_d;
         end
         s2_valid_q  <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sgn_q   <= s1_sgn_q;
            s2_inf_q   <= s1_inf_q;
            s2_zero_q  <= s1_zero_q;
            s2_rnd_q   <= s2_rnd_d;
            s2_stk_q   <= s2_stk_d;
            s2_field_q <= s2_field_d;
         end
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_posit_q <= posit_d;
         end
      end
   end

`ifdef POSIT_NORM_SAT_CNT_EN
   logic        s2_sat_d;
   logic        s2_sat_q, out_sat_q;
   logic [15:0] sat_cnt_q;

   // Specials never count as saturation events.
   assign s2_sat_d = (clamp_hi_s | clamp_lo_s) & !s1_inf_q & !s1_zero_q;

   // Sat flag follows the pipeline; counter steps on each clamped output handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_sat_q  <= 1'b0;
         out_sat_q <= 1'b0;
         sat_cnt_q <= 16'd0;
      end else begin
         if (en_s && s1_valid_q) begin
            s2_sat_q <= s2_sat_d;
         end
         if (en_s && s2_valid_q) begin
            out_sat_q <= s2_sat_q;
         end
         if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
         end
      end
   end

   assign sat_count = sat_cnt_q;
`else
   assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_posit_normalize_es3.sv
module tb_posit_normalize_es3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sgn = 1'b0;
   logic [8:0]  in_scale = 9'h000;
   logic [29:0] in_fraction = 30'h0;
   logic        in_inf = 1'b0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_posit;
   logic [15:0] sat_count;

   int n_checks = 0;
   int n_fail   = 0;

   posit_normalize_es3 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sgn      (in_sgn),
      .in_scale    (in_scale),
      .in_fraction (in_fraction),
      .in_inf      (in_inf),
      .in_zero     (in_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_posit   (out_posit),
      .sat_count   (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [8:0]  scale;
      logic [29:0] frac;
      logic        inf;
      logic        zero;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_sgn      = v.sgn;
      in_scale    = v.scale;
      in_fraction = v.frac;
      in_inf      = v.inf;
      in_zero     = v.zero;
   endtask

   // Single transaction: present, then count negedges until out_valid (bounded).
   task automatic apply_one(input vec_t v, input string nm);
      int cyc;
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, " latency"}, 32'(cyc), 32'd3);
      check(nm, out_posit, v.exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rx [$];
      int idx, got, stall_left, bad;
      bit  stalled;
      logic [31:0] exp_sat;

      vecs[0]  = '{1'b0, 9'h000, 30'h1000_0000, 1'b0, 1'b0, 32'h4000_0000};
      vecs[1]  = '{1'b1, 9'h000, 30'h1000_0000, 1'b0, 1'b0, 32'hC000_0000};
      vecs[2]  = '{1'b0, 9'h000, 30'h2000_0000, 1'b0, 1'b0, 32'h4400_0000};
      vecs[3]  = '{1'b0, 9'h008, 30'h1000_0004, 1'b0, 1'b0, 32'h6000_0000};
      vecs[4]  = '{1'b0, 9'h008, 30'h1000_000C, 1'b0, 1'b0, 32'h6000_0002};
      vecs[5]  = '{1'b0, 9'h005, 30'h0080_0000, 1'b0, 1'b0, 32'h4000_0000};
      vecs[6]  = '{1'b0, 9'h1FF, 30'h1000_0000, 1'b0, 1'b0, 32'h3C00_0000};
      vecs[7]  = '{1'b0, 9'h1F7, 30'h1000_0000, 1'b0, 1'b0, 32'h1E00_0000};
      vecs[8]  = '{1'b1, 9'h008, 30'h1000_000C, 1'b0, 1'b0, 32'h9FFF_FFFE};
      vecs[9]  = '{1'b0, 9'h008, 30'h1000_0006, 1'b0, 1'b0, 32'h6000_0001};
      vecs[10] = '{1'b0, 9'h0EF, 30'h1000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF};
      vecs[11] = '{1'b0, 9'h0F0, 30'h1000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF};
      vecs[12] = '{1'b0, 9'h110, 30'h1000_0000, 1'b0, 1'b0, 32'h0000_0001};
      vecs[13] = '{1'b0, 9'h117, 30'h1000_0000, 1'b0, 1'b0, 32'h0000_0002};
      vecs[14] = '{1'b0, 9'h0FA, 30'h1000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF};
      vecs[15] = '{1'b0, 9'h106, 30'h1000_0000, 1'b0, 1'b0, 32'h0000_0001};
      vecs[16] = '{1'b0, 9'h000, 30'h1000_0000, 1'b1, 1'b0, 32'h8000_0000};
      vecs[17] = '{1'b1, 9'h000, 30'h1000_0000, 1'b0, 1'b1, 32'h0000_0000};
      vecs[18] = '{1'b0, 9'h000, 30'h1000_0000, 1'b1, 1'b1, 32'h8000_0000};
      vecs[19] = '{1'b1, 9'h010, 30'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
      vecs[20] = '{1'b0, 9'h000, 30'h2000_0005, 1'b0, 1'b0, 32'h4400_0001};
      vecs[21] = '{1'b0, 9'h000, 30'h1000_0002, 1'b0, 1'b0, 32'h4000_0000};

      // Reset state
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_posit", out_posit, 32'h0);
      check("reset sat_count", 32'(sat_count), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         apply_one(vecs[i], $sformatf("vec%0d", i));
      end
      @(negedge clk);
`ifdef POSIT_NORM_SAT_CNT_EN
      exp_sat = 32'd2;
`else
      exp_sat = 32'd0;
`endif
      check("sat_count after table", 32'(sat_count), exp_sat);

      // Backpressure: stream 6 values, stall 5 cycles after first output
      idx = 0; got = 0; stall_left = 0; stalled = 1'b0;
      for (int c = 0; c < 80 && got < 6; c++) begin
         @(negedge clk);
         if (idx < 6) begin
            drive(vecs[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
         #1;
         if (stall_left > 0) begin
            check("bp in_ready low", 32'(in_ready), 32'd0);
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp out_posit stable", out_posit, vecs[got].exp);
            stall_left--;
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            rx.push_back(out_posit);
            got++;
            if (!stalled) begin
               stalled    = 1'b1;
               stall_left = 5;
            end
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp delivered count", 32'(rx.size()), 32'd6);
      for (int i = 0; i < 6 && i < rx.size(); i++) begin
         check($sformatf("bp order %0d", i), rx[i], vecs[i].exp);
      end
      repeat (4) @(negedge clk);
      check("bp no duplicate", 32'(out_valid), 32'd0);

      // Reset with values in flight
      drive(vecs[0]);
      in_valid = 1'b1;
      @(negedge clk);
      drive(vecs[3]);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst pre out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst immediate out_valid", 32'(out_valid), 32'd0);
      check("rst immediate out_posit", out_posit, 32'h0);
      check("rst sat_count", 32'(sat_count), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      check("rst no stale output", 32'(bad), 32'd0);
      apply_one(vecs[4], "post reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
